// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle control path.
// Holds the FSM state enum, RV32 opcode values, datapath mux encodings and
// ALU operation codes used by mc_control_path and mc_alu_decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_UPPER,
    S_TRAP
  } state_t;

  // Coarse ALU request from the FSM; FUNCT defers to the instruction fields
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT,
    ALUOP_PASSB
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // The low three bits form the base set; sltu, sra and pass-B carry a
  // fourth bit, so a 3-bit alu_control folds them onto slt, srl and add.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;
  localparam logic [3:0] ALU_SRA   = 4'b1111;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: turns the FSM's coarse ALU request plus funct3/funct7/opcode
// into the ALU operation code. Purely combinational.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [6:0]            op_code,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  alu_op_t               alu_op,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] code;
  logic       unused_fields;

  // Only funct7[5] and opcode bit 5 (R-type vs I-type) select operations
  assign unused_fields = ^{funct7[6], funct7[4:0], op_code[6], op_code[4:0]};

  // funct7[5] selects sub only for R-type; it selects sra for both forms
  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   code = ALU_ADD;
      ALUOP_SUB:   code = ALU_SUB;
      ALUOP_PASSB: code = ALU_PASSB;
      default: begin
        case (funct3)
          3'b000:  code = (op_code[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/mc_control_path.sv
// mc_control_path: multi-cycle RV32 control FSM sharing one ALU and one
// unified memory, with memory wait states and an illegal-instruction trap.
// Optional macro MC_CTRL_UPPER_EN adds lui/auipc through the UPPER state;
// without it those opcodes trap.
module mc_control_path
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int BRANCH_FULL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op_code,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_w,
  output logic                  adr_src,
  output logic                  ir_w,
  output logic                  pc_w,
  output logic                  reg_w,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal
);

  state_t  state;
  state_t  state_next;
  alu_op_t alu_op;
  logic    branch_ok;
  logic    taken;

  // State register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Branch condition; reduced builds accept only beq/bne
  always_comb begin
    branch_ok = 1'b0;
    taken     = 1'b0;
    case (funct3)
      F3_BEQ:  begin branch_ok = 1'b1;               taken = zero;  end
      F3_BNE:  begin branch_ok = 1'b1;               taken = !zero; end
      F3_BLT:  begin branch_ok = (BRANCH_FULL != 0); taken = lt;    end
      F3_BGE:  begin branch_ok = (BRANCH_FULL != 0); taken = !lt;   end
      F3_BLTU: begin branch_ok = (BRANCH_FULL != 0); taken = ltu;   end
      F3_BGEU: begin branch_ok = (BRANCH_FULL != 0); taken = !ltu;  end
      default: begin branch_ok = 1'b0;               taken = 1'b0;  end
    endcase
  end

  // Next state and Moore outputs; only FETCH and BRANCH gate enables on inputs
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_w       = 1'b1;
          pc_w       = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = (op_code == OP_JAL) ? IMM_J : IMM_B;
        case (op_code)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
`ifdef MC_CTRL_UPPER_EN
          OP_LUI, OP_AUIPC:  state_next = S_UPPER;
`endif
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        imm_src    = op_code[5] ? IMM_S : IMM_I;
        state_next = op_code[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_w   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRC_A_RS1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_SUB;
        if (branch_ok) begin
          pc_w       = taken;
          state_next = S_FETCH;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_w       = 1'b1;
        state_next = S_ALUWB;
      end
`ifdef MC_CTRL_UPPER_EN
      S_UPPER: begin
        alu_src_b  = SRC_B_IMM;
        imm_src    = IMM_U;
        alu_src_a  = op_code[5] ? SRC_A_PC : SRC_A_OLDPC;
        alu_op     = op_code[5] ? ALUOP_PASSB : ALUOP_ADD;
        state_next = S_ALUWB;
      end
`endif
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_TRAP;
    endcase
  end

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .op_code    (op_code),
    .funct3     (funct3),
    .funct7     (funct7),
    .alu_op     (alu_op),
    .alu_control(alu_control)
  );

endmodule

// File: tb/tb_mc_control_path.sv
// tb_mc_control_path: directed-vector bench for mc_control_path. A full-branch
// instance carries most sequences; a BRANCH_FULL=0 instance covers the
// reduced branch set. Define MC_CTRL_UPPER_EN to exercise lui via UPPER.
module tb_mc_control_path;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt, ltu, mem_ready;

  logic       mem_req, mem_w, adr_src, ir_w, pc_w, reg_w, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [2:0] alu_control;

  logic       lite_mem_req, lite_mem_w, lite_adr_src, lite_ir_w, lite_pc_w;
  logic       lite_reg_w, lite_illegal;
  logic [1:0] lite_alu_src_a, lite_alu_src_b, lite_result_src;
  logic [2:0] lite_unused_imm;
  logic [2:0] lite_unused_alu;

  int vectors = 0;
  int misses = 0;
  int reg_w_seen = 0;
  int lite_pc_seen = 0;
  int trap_cycles;

  // Field order: mem_req mem_w adr_src ir_w pc_w reg_w a b result illegal
  localparam logic [12:0] FETCH_GO   = 13'b1_0_0_1_1_0_00_10_10_0;
  localparam logic [12:0] FETCH_WAIT = 13'b1_0_0_0_0_0_00_10_10_0;
  localparam logic [12:0] DECODE_S   = 13'b0_0_0_0_0_0_01_01_00_0;
  localparam logic [12:0] MEMADR_S   = 13'b0_0_0_0_0_0_10_01_00_0;
  localparam logic [12:0] MEMREAD_S  = 13'b1_0_1_0_0_0_00_00_00_0;
  localparam logic [12:0] MEMWB_S    = 13'b0_0_0_0_0_1_00_00_01_0;
  localparam logic [12:0] MEMWRITE_S = 13'b1_1_1_0_0_0_00_00_00_0;
  localparam logic [12:0] EXECR_S    = 13'b0_0_0_0_0_0_10_00_00_0;
  localparam logic [12:0] EXECI_S    = 13'b0_0_0_0_0_0_10_01_00_0;
  localparam logic [12:0] ALUWB_S    = 13'b0_0_0_0_0_1_00_00_00_0;
  localparam logic [12:0] BR_TAKEN   = 13'b0_0_0_0_1_0_10_00_00_0;
  localparam logic [12:0] BR_NOT     = 13'b0_0_0_0_0_0_10_00_00_0;
  localparam logic [12:0] JAL_S      = 13'b0_0_0_0_1_0_01_10_00_0;
  localparam logic [12:0] TRAP_S     = 13'b0_0_0_0_0_0_00_00_00_1;
  localparam logic [12:0] UPPER_LUI  = 13'b0_0_0_0_0_0_00_01_00_0;

  mc_control_path #(.ALU_CTRL_W(3), .BRANCH_FULL(1)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_w(mem_w), .adr_src(adr_src), .ir_w(ir_w),
    .pc_w(pc_w), .reg_w(reg_w), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
    .illegal(illegal)
  );

  mc_control_path #(.ALU_CTRL_W(3), .BRANCH_FULL(0)) dut_lite (
    .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(lite_mem_req), .mem_w(lite_mem_w), .adr_src(lite_adr_src),
    .ir_w(lite_ir_w), .pc_w(lite_pc_w), .reg_w(lite_reg_w),
    .alu_src_a(lite_alu_src_a), .alu_src_b(lite_alu_src_b),
    .result_src(lite_result_src), .imm_src(lite_unused_imm),
    .alu_control(lite_unused_alu), .illegal(lite_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] sig(input bit lite);
    if (lite)
      return {lite_mem_req, lite_mem_w, lite_adr_src, lite_ir_w, lite_pc_w,
              lite_reg_w, lite_alu_src_a, lite_alu_src_b, lite_result_src,
              lite_illegal};
    return {mem_req, mem_w, adr_src, ir_w, pc_w, reg_w, alu_src_a, alu_src_b,
            result_src, illegal};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      misses++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z,
                               input logic l, input logic lu);
    op_code = op;
    funct3  = f3;
    funct7  = f7;
    zero    = z;
    lt      = l;
    ltu     = lu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive mem_ready for this cycle, let logic settle, compare one signature
  task automatic stepExpect(input string tag, input logic rdy,
                            input logic [12:0] want, input bit lite = 1'b0);
    mem_ready = rdy;
    #1;
    checkOutput(tag, 32'(sig(lite)), 32'(want));
    if (reg_w) reg_w_seen++;
    if (lite_pc_w) lite_pc_seen++;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    applyStimulus(7'b0000000, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    stepExpect("reset_fetch", 1'b0, FETCH_WAIT);
    tick();

    // R-type add, no waits
    applyStimulus(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
    reg_w_seen = 0;
    stepExpect("radd_c1", 1'b1, FETCH_GO);
    checkOutput("radd_fetch_alu", 32'(alu_control), 32'd0);
    tick();
    stepExpect("radd_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("radd_c3", 1'b1, EXECR_S);
    checkOutput("radd_exec_alu", 32'(alu_control), 32'd0);
    tick();
    stepExpect("radd_c4", 1'b1, ALUWB_S);
    tick();
    checkOutput("radd_regw_count", 32'(reg_w_seen), 32'd1);

    // R-type sub
    applyStimulus(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0);
    stepExpect("rsub_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("rsub_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("rsub_c3", 1'b1, EXECR_S);
    checkOutput("rsub_exec_alu", 32'(alu_control), 32'd1);
    tick();
    stepExpect("rsub_c4", 1'b1, ALUWB_S);
    tick();

    // addi with funct7[5] set must stay add
    applyStimulus(7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0);
    stepExpect("addi_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("addi_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("addi_c3", 1'b1, EXECI_S);
    checkOutput("addi_exec_alu", 32'(alu_control), 32'd0);
    checkOutput("addi_exec_imm", 32'(imm_src), 32'd0);
    tick();
    stepExpect("addi_c4", 1'b1, ALUWB_S);
    tick();

    // lw: two fetch waits and three read waits, ten cycles in total
    applyStimulus(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0);
    reg_w_seen = 0;
    for (int i = 0; i < 2; i++) begin
      stepExpect("lw_fetch_wait", 1'b0, FETCH_WAIT);
      tick();
    end
    stepExpect("lw_fetch_go", 1'b1, FETCH_GO);
    tick();
    stepExpect("lw_decode", 1'b1, DECODE_S);
    tick();
    stepExpect("lw_memadr", 1'b1, MEMADR_S);
    checkOutput("lw_memadr_imm", 32'(imm_src), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      stepExpect("lw_read_wait", 1'b0, MEMREAD_S);
      tick();
    end
    stepExpect("lw_read_go", 1'b1, MEMREAD_S);
    tick();
    stepExpect("lw_memwb", 1'b1, MEMWB_S);
    tick();
    stepExpect("lw_back_to_fetch", 1'b0, FETCH_WAIT);
    tick();
    checkOutput("lw_regw_count", 32'(reg_w_seen), 32'd1);

    // sw, no waits
    applyStimulus(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0);
    stepExpect("sw_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("sw_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("sw_c3", 1'b1, MEMADR_S);
    checkOutput("sw_memadr_imm", 32'(imm_src), 32'd1);
    tick();
    stepExpect("sw_c4", 1'b1, MEMWRITE_S);
    tick();
    stepExpect("sw_back_to_fetch", 1'b0, FETCH_WAIT);
    tick();

    // reset while a store is stalled
    stepExpect("swr_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("swr_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("swr_c3", 1'b1, MEMADR_S);
    tick();
    stepExpect("swr_stall", 1'b0, MEMWRITE_S);
    pulseReset();
    stepExpect("swr_after_rst", 1'b0, FETCH_WAIT);
    tick();

    // bne, zero=0: taken
    applyStimulus(7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0, 1'b0);
    stepExpect("bne_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("bne_c2", 1'b1, DECODE_S);
    checkOutput("bne_decode_imm", 32'(imm_src), 32'd2);
    tick();
    stepExpect("bne_c3", 1'b1, BR_TAKEN);
    checkOutput("bne_branch_alu", 32'(alu_control), 32'd1);
    tick();
    stepExpect("bne_back_to_fetch", 1'b0, FETCH_WAIT);
    tick();

    // bge, lt=1: not taken
    applyStimulus(7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1, 1'b0);
    stepExpect("bge_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("bge_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("bge_c3", 1'b1, BR_NOT);
    tick();

    // bltu, ltu=1 (lt=0): taken
    applyStimulus(7'b1100011, 3'b110, 7'b0000000, 1'b0, 1'b0, 1'b1);
    stepExpect("bltu_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("bltu_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("bltu_c3", 1'b1, BR_TAKEN);
    tick();

    // jal
    applyStimulus(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
    stepExpect("jal_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("jal_c2", 1'b1, DECODE_S);
    checkOutput("jal_decode_imm", 32'(imm_src), 32'd3);
    tick();
    stepExpect("jal_c3", 1'b1, JAL_S);
    tick();
    stepExpect("jal_c4", 1'b1, ALUWB_S);
    tick();

    // reduced branch set: blt must trap and never load the PC
    pulseReset();
    applyStimulus(7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b1, 1'b0);
    lite_pc_seen = 0;
    stepExpect("lite_c1", 1'b1, FETCH_GO, 1'b1);
    tick();
    lite_pc_seen = 0;
    stepExpect("lite_c2", 1'b1, DECODE_S, 1'b1);
    tick();
    stepExpect("lite_c3", 1'b1, BR_NOT, 1'b1);
    tick();
    stepExpect("lite_c4", 1'b1, TRAP_S, 1'b1);
    tick();
    stepExpect("lite_c5", 1'b1, TRAP_S, 1'b1);
    tick();
    checkOutput("lite_pcw_count", 32'(lite_pc_seen), 32'd0);

    // undefined opcode traps, holds, and clears only on reset
    pulseReset();
    applyStimulus(7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
    stepExpect("undef_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("undef_c2", 1'b1, DECODE_S);
    tick();
    stepExpect("undef_c3", 1'b1, TRAP_S);
    trap_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      mem_ready = 1'(i % 2);
      #1;
      if (illegal && !mem_req && !pc_w && !reg_w) trap_cycles++;
    end
    checkOutput("undef_trap_hold", 32'(trap_cycles), 32'd20);
    tick();
    pulseReset();
    stepExpect("undef_cleared", 1'b0, FETCH_WAIT);
    tick();

    // lui
    applyStimulus(7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
    stepExpect("lui_c1", 1'b1, FETCH_GO);
    tick();
    stepExpect("lui_c2", 1'b1, DECODE_S);
    tick();
`ifdef MC_CTRL_UPPER_EN
    stepExpect("lui_upper", 1'b1, UPPER_LUI);
    checkOutput("lui_upper_imm", 32'(imm_src), 32'd4);
    tick();
    stepExpect("lui_aluwb", 1'b1, ALUWB_S);
    tick();
`else
    stepExpect("lui_trap", 1'b1, TRAP_S);
    checkOutput("lui_imm_not_u", 32'(imm_src == 3'b100), 32'd0);
    tick();
    checkOutput("lui_unused_upper_sig", 32'(sig(1'b0) == UPPER_LUI), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
